// File: rtl/mips_defs_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs_pkg
// Shared MIPS pipeline definitions. The M-stage data memory and the control
// unit both import these memory-access encodings so they cannot disagree.
//   MEMOP_*    : 3-bit mem_op encodings (unlisted codes behave as word)
//   DM_BYTES   : data memory size in bytes (16 KiB)
//   accSize_e  : access width class derived from mem_op
//   accessSize : maps a mem_op code onto its access width class
// ---------------------------------------------------------------------------
package mips_defs_pkg;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_HU = 3'b010;
    localparam logic [2:0] MEMOP_B  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;

    localparam int unsigned DM_BYTES = 16384;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } accSize_e;

    // Codes 101..111 fall through to word so a stray control value
    // still produces a well-defined full-word access.
    function automatic accSize_e accessSize(input logic [2:0] op);
        case (op)
            MEMOP_H, MEMOP_HU: return SIZE_HALF;
            MEMOP_B, MEMOP_BU: return SIZE_BYTE;
            default:           return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// ---------------------------------------------------------------------------
// dm_load_ext
// Combinational load formatter for the data memory. Picks the half or byte
// lane addressed by the low address bits and sign- or zero-extends it to
// 32 bits so the W stage receives a final register value.
//   i_word    : full 32-bit word read from the array
//   i_byteOff : addr[1:0] of the access (addr[1] selects the half lane)
//   i_memOp   : mem_op access type
//   o_data    : extended load result
// ---------------------------------------------------------------------------
module dm_load_ext
    import mips_defs_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byteOff,
    input  logic [2:0]  i_memOp,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane selection uses the same addressing as the store merge, so a half
    // access ignores addr[0] and a word access ignores both low bits.
    always_comb begin
        w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];
        case (i_byteOff)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Extension by access type; unlisted codes return the raw word.
    always_comb begin
        case (i_memOp)
            MEMOP_H:  o_data = {{16{w_half[15]}}, w_half};
            MEMOP_HU: o_data = {16'h0000, w_half};
            MEMOP_B:  o_data = {{24{w_byte[7]}}, w_byte};
            MEMOP_BU: o_data = {24'h000000, w_byte};
            default:  o_data = i_word;
        endcase
    end

endmodule

// File: rtl/m_dm.sv
// ---------------------------------------------------------------------------
// m_dm
// M-stage data memory of the 5-stage MIPS pipeline. Stores (sw/sh/sb) are
// merged into the addressed word and written on the rising clock edge;
// loads are read combinationally and extended before the M/W register.
// Every committed store is logged as "@pc: *wordaddr <= mergedword".
//   clk      : clock, rising edge
//   reset    : asynchronous active-high, clears the whole array
//   we       : store enable
//   mem_op   : access type (see mips_defs_pkg)
//   addr     : byte address
//   wdata    : store data (low 8/16 bits used by sb/sh)
//   pc       : PC of the M-stage instruction, for the store log only
//   rdata    : extended load result, 0 for rejected accesses
//   addr_err : misaligned / out-of-range flag
// Build option: define DM_ALIGN_CHECK_EN to flag misaligned accesses on
// addr_err and suppress them; otherwise addr_err is 0 and misaligned
// accesses are aligned down.
// ---------------------------------------------------------------------------
module m_dm
    import mips_defs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_inRange;
    logic                  w_accessOk;
    logic                  w_commit;
    accSize_e              w_size;
    logic [31:0]           w_oldWord;
    logic [31:0]           w_merged;
    logic [31:0]           w_extData;

    assign w_idx     = addr[ADDR_WIDTH+1:2];
    assign w_inRange = (addr[31:ADDR_WIDTH+2] == '0);
    assign w_size    = accessSize(mem_op);
    assign w_oldWord = r_mem[w_idx];

`ifdef DM_ALIGN_CHECK_EN
    logic w_misaligned;

    // A word must sit on a 4-byte boundary and a half on a 2-byte boundary;
    // any violation or out-of-range address blocks both load and store.
    assign w_misaligned = ((w_size == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
                          ((w_size == SIZE_HALF) && addr[0]);
    assign addr_err     = w_misaligned || !w_inRange;
    assign w_accessOk   = !addr_err;
`else
    // Without the check, misaligned accesses simply use their aligned lane;
    // only the range test can reject an access.
    assign addr_err   = 1'b0;
    assign w_accessOk = w_inRange;
`endif

    assign w_commit = we && w_accessOk;

    // Store merge: replace only the addressed lane of the current word so
    // sh/sb keep the untouched bytes.
    always_comb begin
        w_merged = w_oldWord;
        case (w_size)
            SIZE_HALF: begin
                if (addr[1]) w_merged[31:16] = wdata[15:0];
                else         w_merged[15:0]  = wdata[15:0];
            end
            SIZE_BYTE: begin
                case (addr[1:0])
                    2'd0:    w_merged[7:0]   = wdata[7:0];
                    2'd1:    w_merged[15:8]  = wdata[7:0];
                    2'd2:    w_merged[23:16] = wdata[7:0];
                    default: w_merged[31:24] = wdata[7:0];
                endcase
            end
            default: w_merged = wdata;
        endcase
    end

    // Array storage: reset clears every word and blocks writes for as long
    // as it is held; otherwise a committed store lands on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifndef SYNTHESIS
    // Store log for grading; mirrors exactly the condition that writes the
    // array, so suppressed or reset-blocked stores never print.
    always @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
        end
    end
`endif

    dm_load_ext u_loadExt (
        .i_word    (w_oldWord),
        .i_byteOff (addr[1:0]),
        .i_memOp   (mem_op),
        .o_data    (w_extData)
    );

    // Rejected accesses read as zero rather than aliasing another word.
    assign rdata = w_accessOk ? w_extData : 32'h0000_0000;

endmodule

// File: tb/tb_m_dm.sv
// ---------------------------------------------------------------------------
// tb_m_dm
// Directed bench for m_dm: walks through reset, word/half/byte stores and
// loads, same-cycle read/write, out-of-range and misaligned accesses, with
// every expected value written out by hand.
// ---------------------------------------------------------------------------
module tb_m_dm;
    import mips_defs_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        addr_err;

    int compared   = 0;
    int mismatched = 0;

    m_dm #(.ADDR_WIDTH(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .pc       (pc),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one access on the falling edge so it is stable for the next
    // rising edge, then let the combinational read settle.
    task automatic applyStimulus(input logic iWe, input logic [2:0] iOp,
                                 input logic [31:0] iAddr,
                                 input logic [31:0] iData);
        @(negedge clk);
        we     = iWe;
        mem_op = iOp;
        addr   = iAddr;
        wdata  = iData;
        pc     = pc + 32'd4;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Commit a store: drive it, then wait past the rising edge.
    task automatic doStore(input logic [2:0] iOp, input logic [31:0] iAddr,
                           input logic [31:0] iData);
        applyStimulus(1'b1, iOp, iAddr, iData);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        we     = 1'b0;
        mem_op = MEMOP_W;
        addr   = '0;
        wdata  = '0;
        pc     = 32'h0040_0000;
        #3 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        applyStimulus(1'b0, MEMOP_W, 32'h10, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_err", {31'h0, addr_err}, 32'h0);

        // Reset mid-run, including a store attempted while reset is held
        doStore(MEMOP_W, 32'h10, 32'h1234_5678);
        applyStimulus(1'b0, MEMOP_W, 32'h10, 32'h0);
        checkOutput("sw_0x10", rdata, 32'h1234_5678);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", rdata, 32'h0);
        we    = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        #1 checkOutput("no_write_in_reset", rdata, 32'h0);

        // Byte stores and byte loads
        doStore(MEMOP_W, 32'h20, 32'hAABB_CCDD);
        doStore(MEMOP_B, 32'h21, 32'h5566_7711);
        applyStimulus(1'b0, MEMOP_W, 32'h20, 32'h0);
        checkOutput("sb_merge", rdata, 32'hAABB_11DD);
        applyStimulus(1'b0, MEMOP_B, 32'h23, 32'h0);
        checkOutput("lb_0x23", rdata, 32'hFFFF_FFAA);
        applyStimulus(1'b0, MEMOP_BU, 32'h23, 32'h0);
        checkOutput("lbu_0x23", rdata, 32'h0000_00AA);
        applyStimulus(1'b0, MEMOP_B, 32'h21, 32'h0);
        checkOutput("lb_0x21", rdata, 32'h0000_0011);
        applyStimulus(1'b0, MEMOP_BU, 32'h20, 32'h0);
        checkOutput("lbu_0x20", rdata, 32'h0000_00DD);
        applyStimulus(1'b0, 3'b111, 32'h20, 32'h0);
        checkOutput("op111_is_word", rdata, 32'hAABB_11DD);

        // Half stores and half loads
        doStore(MEMOP_H, 32'h32, 32'h1234_8001);
        applyStimulus(1'b0, MEMOP_W, 32'h30, 32'h0);
        checkOutput("sh_merge", rdata, 32'h8001_0000);
        applyStimulus(1'b0, MEMOP_H, 32'h32, 32'h0);
        checkOutput("lh_0x32", rdata, 32'hFFFF_8001);
        applyStimulus(1'b0, MEMOP_HU, 32'h32, 32'h0);
        checkOutput("lhu_0x32", rdata, 32'h0000_8001);
        applyStimulus(1'b0, MEMOP_H, 32'h30, 32'h0);
        checkOutput("lh_0x30", rdata, 32'h0);

        // Same-cycle read and write: old data before the edge, new after
        doStore(MEMOP_W, 32'h40, 32'h5);
        applyStimulus(1'b1, MEMOP_W, 32'h40, 32'h9);
        checkOutput("rw_before_edge", rdata, 32'h5);
        @(posedge clk);
        #1 checkOutput("rw_after_edge", rdata, 32'h9);
        we = 1'b0;

        // Byte into the top lane, signed load of it
        doStore(MEMOP_B, 32'h43, 32'h0000_00EE);
        applyStimulus(1'b0, MEMOP_W, 32'h40, 32'h0);
        checkOutput("sb_lane3", rdata, 32'hEE00_0009);
        applyStimulus(1'b0, MEMOP_B, 32'h43, 32'h0);
        checkOutput("lb_0x43", rdata, 32'hFFFF_FFEE);

        // Out of range: dropped store, zero read, no alias into word 0
        applyStimulus(1'b1, MEMOP_W, 32'h4000, 32'hCAFE_BABE);
        checkOutput("oor_rdata", rdata, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        checkOutput("oor_err", {31'h0, addr_err}, 32'h1);
`else
        checkOutput("oor_err", {31'h0, addr_err}, 32'h0);
`endif
        @(posedge clk);
        #1 we = 1'b0;
        applyStimulus(1'b0, MEMOP_W, 32'h0, 32'h0);
        checkOutput("oor_no_alias", rdata, 32'h0);

        // Misaligned word store to 0x13, then misaligned half load at 0x33
        applyStimulus(1'b1, MEMOP_W, 32'h13, 32'h0BAD_F00D);
`ifdef DM_ALIGN_CHECK_EN
        checkOutput("mis_err", {31'h0, addr_err}, 32'h1);
`else
        checkOutput("mis_err", {31'h0, addr_err}, 32'h0);
`endif
        @(posedge clk);
        #1 we = 1'b0;
        applyStimulus(1'b0, MEMOP_W, 32'h10, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        checkOutput("mis_suppressed", rdata, 32'h0);
`else
        checkOutput("mis_aligned_down", rdata, 32'h0BAD_F00D);
`endif
        applyStimulus(1'b0, MEMOP_H, 32'h33, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        checkOutput("lh_mis_0x33", rdata, 32'h0);
`else
        checkOutput("lh_mis_0x33", rdata, 32'hFFFF_8001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
